// File: rtl/tm_pkg.sv
// Purpose : shared definitions for the tm_* serial-SRAM path (arbiter states, window and gap constants).
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package tm_pkg;

  // Arbiter grant states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no grant
    ST_GNT_A = 2'd1,  // tape port owns the engine
    ST_GNT_B = 2'd2,  // table port owns the engine
    ST_GAP_B = 2'd3   // table port holds a lock between transactions
  } arb_state_t;

  // Port B addresses an offset inside a 4 KiB window of the SRAM.
  localparam int B_WIN_BITS  = 12;

  // Empty GAP_B cycles tolerated before a locked burst is abandoned.
  localparam int GAP_TIMEOUT = 4;
  localparam int GAP_CNT_W   = 3;

  // Width of the remaining-burst counter; LOCK_MAX must fit (1..15).
  localparam int LOCK_CNT_W  = 4;

endpackage

// File: rtl/tm_spi_arb.sv
// Purpose : round-robin two-port arbiter in front of tm_spi; port B is remapped into a fixed SRAM
//           window and may lock the engine for a bounded burst.
// Latency : request seen in IDLE at edge N -> eng_valid_o from cycle N+1; done pulses are
//           combinational from eng_done_i (zero added latency).
// Backpressure: a requester holds valid until its done pulse; the loser of arbitration simply waits.
// Ports   : clk/rst_n (sync, active-low); a_* tape port; b_* table port (12-bit window offset, lock);
//           eng_* command to / completion from tm_spi; rd_data_o broadcast read data; busy_o = not IDLE.
module tm_spi_arb
  import tm_pkg::*;
#(
  parameter logic [15:0] B_BASE   = 16'hF000,
  parameter int          LOCK_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // port A (tape cache)
  input  logic                  a_valid_i,
  input  logic                  a_iswr_i,
  input  logic [15:0]           a_addr_i,
  input  logic [7:0]            a_data_i,
  output logic                  a_done_o,
  // port B (transition-table fetcher)
  input  logic                  b_valid_i,
  input  logic                  b_iswr_i,
  input  logic [B_WIN_BITS-1:0] b_addr_i,
  input  logic [7:0]            b_data_i,
  input  logic                  b_lock_i,
  output logic                  b_done_o,
  // shared read data
  output logic [7:0]            rd_data_o,
  // engine command / completion
  output logic                  eng_valid_o,
  output logic                  eng_iswr_o,
  output logic [15:0]           eng_addr_o,
  output logic [7:0]            eng_data_o,
  input  logic                  eng_done_i,
  input  logic [7:0]            eng_data_i,
  output logic                  busy_o
);

  // A fresh B grant allows LOCK_MAX transactions in total, so LOCK_MAX-1 further ones after the first.
  localparam logic [LOCK_CNT_W-1:0] LOCK_LOAD = LOCK_CNT_W'(LOCK_MAX - 1);
  localparam logic [GAP_CNT_W-1:0]  GAP_LAST  = GAP_CNT_W'(GAP_TIMEOUT - 1);

  arb_state_t            r_state;
  logic                  r_last_b;     // 1: B was served last, so A wins the next tie
  logic [LOCK_CNT_W-1:0] r_lock_cnt;
  logic [GAP_CNT_W-1:0]  r_gap_cnt;    // consecutive empty GAP_B cycles seen so far

  arb_state_t            w_state_nxt;
  logic                  w_last_b_nxt;
  logic [LOCK_CNT_W-1:0] w_lock_cnt_nxt;
  logic [GAP_CNT_W-1:0]  w_gap_cnt_nxt;

  // Round-robin pick: on a tie the port not served last wins; otherwise the sole requester.
  function automatic logic pick_b(input logic a_req, input logic b_req, input logic last_b);
    if (a_req && b_req) begin
      return !last_b;
    end
    return b_req;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_last_b   <= 1'b1;
      r_lock_cnt <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_b   <= w_last_b_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_b_nxt   = r_last_b;
    w_lock_cnt_nxt = r_lock_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (a_valid_i || b_valid_i) begin
          if (pick_b(a_valid_i, b_valid_i, r_last_b)) begin
            w_state_nxt    = ST_GNT_B;
            w_lock_cnt_nxt = LOCK_LOAD;
          end else begin
            w_state_nxt    = ST_GNT_A;
          end
        end
      end
      ST_GNT_A: begin
        if (eng_done_i) begin
          w_last_b_nxt = 1'b0;
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_GNT_B: begin
        if (eng_done_i) begin
          w_last_b_nxt = 1'b1;
          // A zero count ends the burst, so the counter can never underflow.
          if (b_lock_i && (r_lock_cnt != '0)) begin
            w_lock_cnt_nxt = r_lock_cnt - LOCK_CNT_W'(1);
            w_gap_cnt_nxt  = '0;
            w_state_nxt    = ST_GAP_B;
          end else begin
            w_state_nxt    = ST_IDLE;
          end
        end
      end
      ST_GAP_B: begin
        // Dropping the lock releases the engine even if B is asking again.
        if (!b_lock_i) begin
          w_state_nxt = ST_IDLE;
        end else if (b_valid_i) begin
          w_state_nxt = ST_GNT_B;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + GAP_CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic: inline port mux; everything toward the engine is zero outside a grant.
  always_comb begin
    eng_valid_o = 1'b0;
    eng_iswr_o  = 1'b0;
    eng_addr_o  = '0;
    eng_data_o  = '0;
    a_done_o    = 1'b0;
    b_done_o    = 1'b0;
    unique case (r_state)
      ST_GNT_A: begin
        eng_valid_o = a_valid_i;
        eng_iswr_o  = a_iswr_i;
        eng_addr_o  = a_addr_i;
        eng_data_o  = a_data_i;
        a_done_o    = eng_done_i;
      end
      ST_GNT_B: begin
        eng_valid_o = b_valid_i;
        eng_iswr_o  = b_iswr_i;
        eng_addr_o  = B_BASE | {{(16 - B_WIN_BITS){1'b0}}, b_addr_i};
        eng_data_o  = b_data_i;
        b_done_o    = eng_done_i;
      end
      default: begin
      end
    endcase
  end

  assign rd_data_o = eng_data_i;
  assign busy_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_tm_spi_arb.sv
// Purpose : scoreboard bench for tm_spi_arb with requester drivers and a fixed-latency engine model.
// Latency : engine answers in the second cycle of each command.
// Backpressure: drivers hold valid until their done pulse, then drop it for one cycle.
`timescale 1ns/1ps
module tb_tm_spi_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid_i, a_iswr_i, a_done_o;
  logic [15:0] a_addr_i;
  logic [7:0]  a_data_i;
  logic        b_valid_i, b_iswr_i, b_lock_i, b_done_o;
  logic [11:0] b_addr_i;
  logic [7:0]  b_data_i;
  logic [7:0]  rd_data_o;
  logic        eng_valid_o, eng_iswr_o, eng_done_i, busy_o;
  logic [15:0] eng_addr_o;
  logic [7:0]  eng_data_o, eng_data_i;
  logic        abort;

  always #5 clk = ~clk;

  tm_spi_arb #(.B_BASE(16'hF000), .LOCK_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid_i(a_valid_i), .a_iswr_i(a_iswr_i), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
    .a_done_o(a_done_o),
    .b_valid_i(b_valid_i), .b_iswr_i(b_iswr_i), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
    .b_lock_i(b_lock_i), .b_done_o(b_done_o),
    .rd_data_o(rd_data_o),
    .eng_valid_o(eng_valid_o), .eng_iswr_o(eng_iswr_o), .eng_addr_o(eng_addr_o),
    .eng_data_o(eng_data_o), .eng_done_i(eng_done_i), .eng_data_i(eng_data_i),
    .busy_o(busy_o)
  );

  typedef struct packed {
    logic        iswr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        lock;
  } req_t;

  typedef struct packed {
    logic        vld;
    logic        port_b;
    logic        iswr;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  req_t qa[$];
  req_t qb[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired, got no event, required one (t=%0t)", name, $time);
  endtask

  task automatic push_a(input logic iswr, input logic [15:0] addr, input logic [7:0] data);
    req_t r;
    r.iswr = iswr; r.addr = addr; r.data = data; r.lock = 1'b0;
    qa.push_back(r);
  endtask

  task automatic push_b(input logic iswr, input logic [11:0] off, input logic [7:0] data,
                        input logic lock);
    req_t r;
    r.iswr = iswr; r.addr = {4'h0, off}; r.data = data; r.lock = lock;
    qb.push_back(r);
  endtask

  task automatic expect_cmd(input logic port_b, input logic iswr, input logic [15:0] addr,
                            input logic [7:0] data);
    exp_t e;
    e.vld = 1'b1; e.port_b = port_b; e.iswr = iswr; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_quiet(input string name);
    int n;
    int calm;
    n = 0;
    calm = 0;
    while (calm < 2 && n < 600) begin
      @(negedge clk);
      n++;
      if (qa.size() == 0 && qb.size() == 0 && !a_valid_i && !b_valid_i && !busy_o) calm++;
      else calm = 0;
    end
    if (calm < 2) bound_expired(name);
  endtask

  // Port A requester.
  initial begin : drv_a
    req_t r;
    int   n;
    a_valid_i = 1'b0; a_iswr_i = 1'b0; a_addr_i = '0; a_data_i = '0;
    forever begin
      @(posedge clk); #1;
      if (qa.size() != 0) begin
        r = qa.pop_front();
        a_valid_i = 1'b1; a_iswr_i = r.iswr; a_addr_i = r.addr; a_data_i = r.data;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!a_done_o && !abort && n < 400);
        if (!a_done_o && !abort) bound_expired("a_done_wait");
        @(posedge clk); #1;
        a_valid_i = 1'b0; a_iswr_i = 1'b0; a_addr_i = '0; a_data_i = '0;
      end
    end
  end

  // Port B requester; the lock level is kept across the one-cycle valid gap.
  initial begin : drv_b
    req_t r;
    int   n;
    b_valid_i = 1'b0; b_iswr_i = 1'b0; b_addr_i = '0; b_data_i = '0; b_lock_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (qb.size() != 0) begin
        r = qb.pop_front();
        b_valid_i = 1'b1; b_iswr_i = r.iswr; b_addr_i = r.addr[11:0]; b_data_i = r.data;
        b_lock_i  = r.lock;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!b_done_o && !abort && n < 400);
        if (!b_done_o && !abort) bound_expired("b_done_wait");
        @(posedge clk); #1;
        b_valid_i = 1'b0; b_iswr_i = 1'b0; b_addr_i = '0; b_data_i = '0;
      end
    end
  end

  // Engine model: completes each command in its second valid cycle with a fresh data byte.
  initial begin : engine
    int         cnt;
    logic [7:0] rsp;
    cnt = 0;
    rsp = 8'h30;
    eng_done_i = 1'b0;
    eng_data_i = '0;
    forever begin
      @(posedge clk); #2;
      eng_done_i = 1'b0;
      if (!rst_n || !eng_valid_o) begin
        cnt = 0;
      end else begin
        cnt++;
        if (cnt == 2) begin
          eng_done_i = 1'b1;
          eng_data_i = rsp;
          rsp = rsp + 8'd7;
          cnt = 0;
        end
      end
    end
  end

  // Monitor: every done pulse consumes one scoreboard entry.
  initial begin : monitor
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk);
      if (a_done_o || b_done_o) begin
        act = {eng_valid_o, b_done_o, eng_iswr_o, eng_addr_o, eng_data_o};
        if (a_done_o && b_done_o) begin
          check("done_exclusive", 32'({a_done_o, b_done_o}), 32'b01);
        end
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(act), 32'h0);
        end else begin
          e = sb.pop_front();
          check("sb_cmd", 32'(act), 32'(e));
          check("sb_rd_data", 32'(rd_data_o), 32'(eng_data_i));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    rst_n = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({eng_valid_o, eng_iswr_o, eng_addr_o, eng_data_o, a_done_o, b_done_o, busy_o}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy_o), 32'h0);

    // A alone: one-cycle grant latency and a single-cycle done pulse.
    push_a(1'b0, 16'h0012, 8'h00);
    expect_cmd(1'b0, 1'b0, 16'h0012, 8'h00);
    @(negedge clk);
    check("lat_idle_cycle", 32'({eng_valid_o, busy_o}), 32'b00);
    @(negedge clk);
    check("lat_grant_cycle", 32'({eng_valid_o, busy_o, eng_addr_o}), {14'h0, 2'b11, 16'h0012});
    n = 0;
    while (!a_done_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_done_o) bound_expired("a_alone_done");
    @(negedge clk);
    check("a_done_one_cycle", 32'({a_done_o, busy_o}), 32'b00);
    wait_quiet("quiet_a_alone");

    // B alone, write into the window.
    push_b(1'b1, 12'h034, 8'hA5, 1'b0);
    expect_cmd(1'b1, 1'b1, 16'hF034, 8'hA5);
    wait_quiet("quiet_b_alone");

    // Tie with B served last: A first, then alternation.
    push_a(1'b0, 16'h0100, 8'h00);
    push_a(1'b1, 16'h0101, 8'h11);
    push_b(1'b0, 12'h200, 8'h00, 1'b0);
    push_b(1'b1, 12'h201, 8'h22, 1'b0);
    expect_cmd(1'b0, 1'b0, 16'h0100, 8'h00);
    expect_cmd(1'b1, 1'b0, 16'hF200, 8'h00);
    expect_cmd(1'b0, 1'b1, 16'h0101, 8'h11);
    expect_cmd(1'b1, 1'b1, 16'hF201, 8'h22);
    wait_quiet("quiet_alternate");

    // Tie with A served last: B wins.
    push_a(1'b0, 16'h0300, 8'h00);
    expect_cmd(1'b0, 1'b0, 16'h0300, 8'h00);
    wait_quiet("quiet_a_before_tie");
    push_a(1'b1, 16'h0301, 8'h33);
    push_b(1'b1, 12'h302, 8'h44, 1'b0);
    expect_cmd(1'b1, 1'b1, 16'hF302, 8'h44);
    expect_cmd(1'b0, 1'b1, 16'h0301, 8'h33);
    wait_quiet("quiet_tie_b");

    // Locked B burst of 10 with A pending: 8 B, then A, then the last 2 B.
    for (int i = 0; i < 10; i++) push_b(1'b0, 12'h100 + 12'(i), 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) expect_cmd(1'b1, 1'b0, 16'hF100 + 16'(i), 8'h00);
    expect_cmd(1'b0, 1'b1, 16'h0400, 8'h55);
    expect_cmd(1'b1, 1'b0, 16'hF108, 8'h00);
    expect_cmd(1'b1, 1'b0, 16'hF109, 8'h00);
    repeat (2) @(negedge clk);
    push_a(1'b1, 16'h0400, 8'h55);
    wait_quiet("quiet_lock_burst");

    // GAP_B timeout: 4 empty gap cycles, IDLE on the 5th, A granted on the 6th.
    push_b(1'b0, 12'h0AB, 8'h00, 1'b1);
    expect_cmd(1'b1, 1'b0, 16'hF0AB, 8'h00);
    expect_cmd(1'b0, 1'b0, 16'h0500, 8'h00);
    repeat (2) @(negedge clk);
    push_a(1'b0, 16'h0500, 8'h00);
    n = 0;
    while (!b_done_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b_done_o) bound_expired("gap_b_done");
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("gap_cycle_%0d", k), 32'({busy_o, eng_valid_o}), 32'b10);
    end
    @(negedge clk);
    check("gap_timeout_idle", 32'({busy_o, eng_valid_o}), 32'b00);
    @(negedge clk);
    check("gap_then_a_grant", 32'({eng_valid_o, eng_addr_o}), {15'h0, 1'b1, 16'h0500});
    wait_quiet("quiet_gap_timeout");

    // Reset in the middle of a B transaction: abandoned, then a tie grants A.
    push_b(1'b0, 12'h055, 8'h00, 1'b0);
    n = 0;
    while (!eng_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!eng_valid_o) bound_expired("rst_b_grant");
    rst_n = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    check("rst_mid_txn", 32'({eng_valid_o, busy_o, b_done_o, a_done_o}), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    check("rst_release_idle", 32'({busy_o, b_valid_i}), 32'b00);
    push_a(1'b0, 16'h0600, 8'h00);
    push_b(1'b0, 12'h600, 8'h00, 1'b0);
    expect_cmd(1'b0, 1'b0, 16'h0600, 8'h00);
    expect_cmd(1'b1, 1'b0, 16'hF600, 8'h00);
    wait_quiet("quiet_after_reset");

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tm_spi_arb.md
# tm_spi_arb

Two-port arbiter placed in front of the single `tm_spi` engine, so that the tape cache and the transition-table fetcher share one serial SRAM. It grants the engine to one requester at a time, round-robin, and remaps port B into a fixed SRAM window. Port B may lock the bus for a bounded burst of back-to-back transactions. It sits between `tm_tape`/table fetcher and `tm_spi` in the top-level.

## Interface
Parameters:
- `B_BASE`, 16'hF000, SRAM base address of port B's window; the low 12 bits must be 0.
- `LOCK_MAX`, 8, maximum consecutive port-B transactions under lock (1..15).

Ports:
- `clk`  in  1  single design clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `a_valid_i`  in  1  port A (tape) request; held high until `a_done_o`.
- `a_iswr_i`  in  1  port A write (1) / read (0).
- `a_addr_i`  in  16  port A byte address, passed through unchanged.
- `a_data_i`  in  8  port A write data.
- `a_done_o`  out  1  one-cycle completion pulse to port A.
- `b_valid_i`, `b_iswr_i`, `b_data_i`  in  1/1/8  port B equivalents.
- `b_addr_i`  in  12  port B offset inside its window.
- `b_lock_i`  in  1  port B requests to keep the grant after its current transaction.
- `b_done_o`  out  1  one-cycle completion pulse to port B.
- `rd_data_o`  out  8  engine read data, broadcast to both ports; valid in the cycle of the port's done pulse.
- `eng_valid_o`, `eng_iswr_o`, `eng_addr_o[15:0]`, `eng_data_o[7:0]`  out  engine command.
- `eng_done_i`  in  1  engine completion pulse.
- `eng_data_i`  in  8  engine read data.
- `busy_o`  out  1  high when the arbiter is not in IDLE.

## Operation
- States:
  - IDLE: no grant.
  - GNT_A: port A granted.
  - GNT_B: port B granted.
  - GAP_B: port B locked, waiting for its next request.
- IDLE:
  - If both ports are valid, grant the port that was not `last`.
  - If only one port is valid, grant it.
  - On granting B, load `lock_cnt` with `LOCK_MAX-1`.
- GNT_A:
  - `eng_*` is driven from port A.
  - On `eng_done_i`: pulse `a_done_o`, set `last`=A, go to IDLE.
- GNT_B:
  - `eng_addr_o` = `B_BASE | {4'b0, b_addr_i}`.
  - On `eng_done_i`: pulse `b_done_o` and set `last`=B.
  - Then, if `b_lock_i`=1 and `lock_cnt`≠0, decrement `lock_cnt` and go to GAP_B; otherwise go to IDLE.
- GAP_B:
  - `eng_valid_o`=0.
  - The next cycle in which `b_valid_i`=1 returns to GNT_B.
  - If `b_lock_i` drops, or `b_valid_i` stays 0 for 4 consecutive GAP_B cycles, go to IDLE.
  - Port A waits while in GAP_B.
- `eng_valid_o` = (GNT_A & `a_valid_i`) | (GNT_B & `b_valid_i`). All `eng_*` outputs are 0 when neither grant state is active.
- `eng_done_i` arriving outside GNT_A/GNT_B is ignored; no done pulse is generated.
- A requester that drops valid while granted is a protocol violation. The grant remains until `eng_done_i`.
- `lock_cnt` is 4 bits and never wraps below 0.

## Timing
- Reset (`rst_n`=0 at a clk edge):
  - State becomes IDLE, `last`=B (so A wins the first tie), `lock_cnt`=0.
  - All `eng_*` outputs, both done pulses, and `busy_o` are 0.
  - A transaction in flight is abandoned; `tm_spi` shares the same reset.
- Grant latency: a request seen in IDLE at edge N produces `eng_valid_o`=1 from cycle N+1.
- Done: `x_done_o` is combinational from `eng_done_i` in the granted state, with zero added latency.
- After a done pulse, the state is IDLE or GAP_B for at least one cycle. Requesters deassert valid in that cycle, so there is no double-grant.
- Worst-case wait for A is one B burst of `LOCK_MAX` transactions, plus at most 4 idle cycles per gap.

## Structure
- Shared package `tm_pkg`: state encoding, the `B_WIN_BITS`=12 constant, and the gap timeout value 4.
- Single module with no sub-modules. The port mux is inline; the round-robin decision is a small combinational function local to the module.

## Test plan
- Reset, then A alone (read, addr 16'h0012): `eng_valid_o` rises 1 cycle after the request, `eng_addr_o`=16'h0012. On the engine done, `a_done_o` pulses one cycle and `rd_data_o`=`eng_data_i`.
- B alone, `b_addr_i`=12'h034, write 8'hA5: `eng_addr_o`=16'hF034, `eng_iswr_o`=1, `eng_data_o`=8'hA5.
- A and B valid in the same cycle after reset: A is granted first. After A's done, with both asserted again, B is granted. They alternate thereafter.
- B holds `b_lock_i`=1 for 10 transactions while A is pending, with `LOCK_MAX`=8: B completes exactly 8, then A is granted, then B resumes.
- GAP_B timeout: B locked, then no `b_valid_i` for 4 cycles: IDLE and `busy_o`=0 on the 5th cycle; a pending A is granted next.
- `rst_n` low mid-transaction in GNT_B: the next cycle shows `eng_valid_o`=0, `busy_o`=0, no done pulse. After release, a tie grants A.
